// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the single-cycle MIPS-style core: opcode constants,
//   the fetch FSM state encoding and the default reset PC.
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SUBI  = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // StReq: waiting for imem ack; StIssue: instr presented to decode
   typedef enum logic {
      StReq,
      StIssue
   } fetchStateT;

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
//   Combinational next-PC selection for the fetch stage.
//   Ports:
//     pcPlus4_i   - address of the sequentially next instruction
//     instrIdx_i  - instr[25:0] of the current instruction (jump index / imm)
//     branch_i    - beq qualifier from control unit
//     zero_i      - ALU zero flag
//     jump_i      - jump select from control unit
//     nextPc_o    - selected next PC (jump > taken branch > sequential)
// ----------------------------------------------------------------------------
module next_pc_calc #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pcPlus4_i,
   input  logic [25:0]       instrIdx_i,
   input  logic              branch_i,
   input  logic              zero_i,
   input  logic              jump_i,
   output logic [ADDR_W-1:0] nextPc_o
);

   logic [ADDR_W-1:0] jumpTarget;
   logic [ADDR_W-1:0] branchOffset;
   logic [ADDR_W-1:0] branchTarget;

   // Jump keeps the upper region bits of the sequential PC
   assign jumpTarget   = {pcPlus4_i[ADDR_W-1:28], instrIdx_i, 2'b00};
   // Word offset, sign-extended and scaled to bytes
   assign branchOffset = {{(ADDR_W-18){instrIdx_i[15]}}, instrIdx_i[15:0], 2'b00};
   assign branchTarget = pcPlus4_i + branchOffset;

   always_comb begin
      nextPc_o = pcPlus4_i;
      if (jump_i) begin
         nextPc_o = jumpTarget;
      end else if (branch_i && zero_i) begin
         nextPc_o = branchTarget;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage: holds the PC, fetches one word at a time over a req/ack
//   handshake and presents it to decode until it is retired.
//   Ports:
//     clk, rst             - clock, synchronous active-high reset
//     imem_req/imem_addr   - registered fetch request, address (= pc)
//     imem_ack/imem_rdata  - memory response, word valid when ack=1
//     instr/op/funct       - held instruction and its op/funct fields
//     instr_valid          - instr holds a fetched, not yet retired word
//     instr_ready          - downstream retires instr this cycle
//     branch/zero/jump     - next-PC qualifiers, sampled at retire
//     pc/pc_plus4          - current instruction address and pc + 4
//     retired_cnt          - instructions retired since reset (wraps)
// ----------------------------------------------------------------------------
module instr_fetch
   import mips_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [5:0]        op,
   output logic [5:0]        funct,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch,
   input  logic              zero,
   input  logic              jump,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [31:0]       retired_cnt
);

   fetchStateT        state_q, state_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       retiredCnt_q, retiredCnt_d;
   logic [ADDR_W-1:0] pcPlus4;
   logic [ADDR_W-1:0] nextPc;

   assign pcPlus4 = pc_q + ADDR_W'(4);

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_nextPcCalc (
      .pcPlus4_i  (pcPlus4),
      .instrIdx_i (instr_q[25:0]),
      .branch_i   (branch),
      .zero_i     (zero),
      .jump_i     (jump),
      .nextPc_o   (nextPc)
   );

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      retiredCnt_d = retiredCnt_q;
      case (state_q)
         StReq: begin
            // req is low only in the first cycle after reset; raise it then
            req_d = 1'b1;
            if (req_q && imem_ack) begin
               instr_d = imem_rdata;
               req_d   = 1'b0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (instr_ready) begin
               pc_d         = nextPc;
               retiredCnt_d = retiredCnt_q + 32'd1;
               req_d        = 1'b1;
               state_d      = StReq;
            end
         end
         default: begin
            state_d = StReq;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StReq;
         req_q        <= 1'b0;
         instr_q      <= '0;
         pc_q         <= RESET_PC;
         retiredCnt_q <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         retiredCnt_q <= retiredCnt_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign instr_valid = (state_q == StIssue);
   assign pc          = pc_q;
   assign pc_plus4    = pcPlus4;
   assign retired_cnt = retiredCnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed and randomized stimulus for instr_fetch, checked against a
//   behavioural model of the PC, retired count and held instruction.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired_cnt;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Reference state
   logic [31:0] mPc;
   logic [31:0] mCnt;
   logic [31:0] mInstr;

   instr_fetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Next PC from the architectural rules: jump > taken beq > sequential
   function automatic logic [31:0] refNext(input logic [31:0] p, input logic [31:0] w,
                                           input bit b, input bit z, input bit j);
      logic [31:0] seq;
      logic [15:0] imm;
      seq = p + 32'd4;
      imm = w[15:0];
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (b && z) return seq + 32'($signed(imm) * 4);
      return seq;
   endfunction

   // Reset for one cycle, optionally with a stray ack in the reset cycle
   task automatic doReset(input bit ackInReset);
      rst        = 1'b1;
      imem_ack   = ackInReset;
      imem_rdata = $urandom;
      tick();
      rst      = 1'b0;
      imem_ack = 1'b0;
      mPc      = RST_PC;
      mCnt     = 32'd0;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_op", {26'd0, op}, 32'd0);
      chk("rst_funct", {26'd0, funct}, 32'd0);
      chk("rst_pc", pc, mPc);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_cnt", retired_cnt, mCnt);
      tick();
      chk("rst_req_rise", {31'd0, imem_req}, 32'd1);
      chk("rst_req_addr", imem_addr, mPc);
   endtask

   // Wait lat cycles with no ack, then return word
   task automatic fetch(input logic [31:0] word, input int lat);
      for (int i = 0; i < lat; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, mPc);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
         tick();
      end
      instr_ready = 1'b0;
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, mPc);
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mInstr     = word;
      chk("instr", instr, mInstr);
      chk("op", {26'd0, op}, mInstr >> 26);
      chk("funct", {26'd0, funct}, mInstr & 32'h3F);
      chk("valid", {31'd0, instr_valid}, 32'd1);
      chk("req_low", {31'd0, imem_req}, 32'd0);
      chk("pc", pc, mPc);
      chk("pc_plus4", pc_plus4, mPc + 32'd4);
   endtask

   // Stall with spurious acks, then retire with the given qualifiers
   task automatic retire(input int stall, input bit b, input bit z, input bit j);
      for (int i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         imem_ack    = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         branch      = 1'($urandom_range(0, 1));
         zero        = 1'($urandom_range(0, 1));
         jump        = 1'($urandom_range(0, 1));
         tick();
         chk("stall_instr", instr, mInstr);
         chk("stall_pc", pc, mPc);
         chk("stall_cnt", retired_cnt, mCnt);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      branch      = b;
      zero        = z;
      jump        = j;
      tick();
      instr_ready = 1'b0;
      branch      = 1'b0;
      zero        = 1'b0;
      jump        = 1'b0;
      mPc         = refNext(mPc, mInstr, b, z, j);
      mCnt        = mCnt + 32'd1;
      chk("ret_valid", {31'd0, instr_valid}, 32'd0);
      chk("ret_req", {31'd0, imem_req}, 32'd1);
      chk("ret_addr", imem_addr, mPc);
      chk("ret_cnt", retired_cnt, mCnt);
   endtask

   initial begin
      rst         = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      branch      = 1'b0;
      zero        = 1'b0;
      jump        = 1'b0;
      mPc         = RST_PC;
      mCnt        = 32'd0;
      mInstr      = 32'd0;

      doReset(1'b0);

      // addi with 3-cycle memory latency, plain retire
      fetch(32'h2008_0005, 3);
      chk("addi_op", {26'd0, op}, 32'd8);
      retire(0, 1'b0, 1'b0, 1'b0);
      chk("pc_after_addi", pc, 32'h4);

      // beq taken / not taken from pc=8
      fetch(32'h0800_0002, 0);
      retire(0, 1'b0, 1'b0, 1'b1);
      fetch(32'h1000_0003, 1);
      retire(0, 1'b1, 1'b1, 1'b0);
      chk("beq_taken", imem_addr, 32'h18);
      fetch(32'h0800_0002, 0);
      retire(0, 1'b0, 1'b0, 1'b1);
      fetch(32'h1000_0003, 0);
      retire(0, 1'b1, 1'b0, 1'b0);
      chk("beq_not_taken", imem_addr, 32'hC);

      // jump wins over a taken branch
      fetch(32'h0800_0007, 0);
      retire(0, 1'b0, 1'b0, 1'b1);
      fetch(32'h0800_0010, 2);
      retire(0, 1'b1, 1'b1, 1'b1);
      chk("jump_priority", imem_addr, 32'h40);

      // Self-loop, wrap to top of memory, then wrap to zero
      fetch(32'h0800_0004, 0);
      retire(0, 1'b0, 1'b0, 1'b1);
      fetch(32'h1000_FFFF, 0);
      retire(0, 1'b1, 1'b1, 1'b0);
      chk("self_loop", pc, 32'h10);
      fetch(32'h1000_FFFA, 0);
      retire(0, 1'b1, 1'b1, 1'b0);
      chk("to_top", pc, 32'hFFFF_FFFC);
      fetch(32'h0000_0020, 0);
      chk("top_plus4", pc_plus4, 32'h0);

      // Long stall with spurious acks
      retire(5, 1'b0, 1'b0, 1'b0);
      chk("pc_wrap", pc, 32'h0);

      // Reset in REQ with a late ack
      fetch(32'h3C01_1234, 1);
      retire(0, 1'b0, 1'b0, 1'b0);
      doReset(1'b1);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         bit b;
         bit z;
         bit j;
         if ($urandom_range(0, 15) == 0) doReset($urandom_range(0, 1) == 1);
         fetch($urandom, int'($urandom_range(0, 3)));
         b = ($urandom_range(0, 1) == 1);
         z = ($urandom_range(0, 1) == 1);
         j = ($urandom_range(0, 3) == 0);
         retire(int'($urandom_range(0, 2)), b, z, j);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
